// File: rtl/adc_pulse_emulator.sv
// Synthetic twin-sample ADC source: baseline on all channels, one programmable
// rectangular pulse each on channels a/b/c, placed with single-sample resolution.
module adc_pulse_emulator #(
    parameter int ADC_DATA_WIDTH      = 16,
    parameter int ADC_TWIN_DATA_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH  = 32
) (
    input  logic                           rxclk,
    input  logic                           rst,
    input  logic                           gen_enable,
    input  logic                           gen_start,
    input  logic [ADC_DATA_WIDTH-1:0]      baseline,
    input  logic [ADC_DATA_WIDTH-1:0]      amp_a,
    input  logic [ADC_DATA_WIDTH-1:0]      amp_b,
    input  logic [ADC_DATA_WIDTH-1:0]      amp_c,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]  init_delay,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]  delay_ab,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]  delay_bc,
    input  logic [ADC_DATA_WIDTH-1:0]      pulse_width,
    output logic [ADC_TWIN_DATA_WIDTH-1:0] adc_data_a,
    output logic [ADC_TWIN_DATA_WIDTH-1:0] adc_data_b,
    output logic [ADC_TWIN_DATA_WIDTH-1:0] adc_data_c,
    output logic [ADC_TWIN_DATA_WIDTH-1:0] adc_data_d,
    output logic                           adc_valid,
    output logic                           gen_busy,
    output logic                           gen_done,
    output logic                           cfg_err,
    output logic [C_S_AXI_DATA_WIDTH-1:0]  tof_ab_cycles
);
    localparam int DW = ADC_DATA_WIDTH;
    localparam int AW = C_S_AXI_DATA_WIDTH;
    localparam int SW = AW + 2;  // two guard bits expose schedule overflow
    localparam int TW = ADC_TWIN_DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] base, input logic [DW-1:0] amp);
        logic [DW:0] sum;
        sum = {base[DW-1], base} + {amp[DW-1], amp};
        if (sum[DW] != sum[DW-1]) begin
            sat_add = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            sat_add = sum[DW-1:0];
        end
    endfunction

    function automatic logic [DW-1:0] chan_sample(input logic [SW-1:0] s, input logic [SW-1:0] t_start,
                                                  input logic [SW-1:0] width, input logic [DW-1:0] base,
                                                  input logic [DW-1:0] level);
        if ((s >= t_start) && (s < (t_start + width))) begin
            chan_sample = level;
        end else begin
            chan_sample = base;
        end
    endfunction

    state_t          state_r, state_next_s;
    logic [AW-1:0]   n_r, t_a_r, t_b_r, t_c_r, t_e_r, tof_r;
    logic [DW-1:0]   width_r, base_r, lev_a_r, lev_b_r, lev_c_r;
    logic            first_done_r, cfg_err_r;
    logic [TW-1:0]   data_a_r, data_b_r, data_c_r, data_d_r;
    logic            valid_r, busy_r, done_r;
    logic [SW-1:0]   t_a_s, t_b_s, t_c_s, t_e_s, even_s, odd_s, wid_s;
    logic            sched_ovf_s, run_end_s;
    logic [TW-1:0]   data_a_s, data_b_s, data_c_s, data_d_s;
    logic            valid_s, busy_s, done_s;

    // Schedule arithmetic on live config, evaluated in ARM, plus run-end test.
    always_comb begin
        t_a_s       = {2'b00, init_delay};
        t_b_s       = t_a_s + {2'b00, delay_ab};
        t_c_s       = t_b_s + {2'b00, delay_bc};
        t_e_s       = t_c_s + {{(SW-DW){1'b0}}, pulse_width};
        sched_ovf_s = |t_e_s[SW-1:AW];
        even_s      = {2'b00, n_r};
        odd_s       = even_s + {{(SW-2){1'b0}}, 2'd1};
        wid_s       = {{(SW-DW){1'b0}}, width_r};
        run_end_s   = (even_s + {{(SW-2){1'b0}}, 2'd2}) >= {2'b00, t_e_r};
    end

    // Next-state logic; gen_enable low forces IDLE from any state.
    always_comb begin
        state_next_s = state_r;
        if (!gen_enable) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_next_s = gen_start ? ST_ARM : ST_IDLE;
                ST_ARM:  state_next_s = sched_ovf_s ? ST_IDLE : ST_RUN;
                ST_RUN:  state_next_s = run_end_s ? ST_DONE : ST_RUN;
                ST_DONE: state_next_s = gen_start ? ST_ARM : ST_DONE;
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // Next values for the registered data/status outputs.
    always_comb begin
        data_a_s = {baseline, baseline};
        data_b_s = {baseline, baseline};
        data_c_s = {baseline, baseline};
        data_d_s = {baseline, baseline};
        valid_s  = 1'b0;
        done_s   = 1'b0;
        busy_s   = (state_next_s == ST_ARM) || (state_next_s == ST_RUN);
        case (gen_enable ? state_r : ST_IDLE)
            ST_RUN: begin
                data_a_s = {chan_sample(odd_s, {2'b00, t_a_r}, wid_s, base_r, lev_a_r),
                            chan_sample(even_s, {2'b00, t_a_r}, wid_s, base_r, lev_a_r)};
                data_b_s = {chan_sample(odd_s, {2'b00, t_b_r}, wid_s, base_r, lev_b_r),
                            chan_sample(even_s, {2'b00, t_b_r}, wid_s, base_r, lev_b_r)};
                data_c_s = {chan_sample(odd_s, {2'b00, t_c_r}, wid_s, base_r, lev_c_r),
                            chan_sample(even_s, {2'b00, t_c_r}, wid_s, base_r, lev_c_r)};
                data_d_s = {base_r, base_r};
                valid_s  = 1'b1;
            end
            ST_DONE: begin
                data_a_s = {base_r, base_r};
                data_b_s = {base_r, base_r};
                data_c_s = {base_r, base_r};
                data_d_s = {base_r, base_r};
                valid_s  = 1'b1;
                done_s   = first_done_r;
            end
            default: begin
                valid_s = 1'b0;
            end
        endcase
    end

    // State register and sample counter.
    always_ff @(posedge rxclk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            n_r          <= {AW{1'b0}};
            first_done_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            n_r          <= (state_r == ST_RUN) ? (n_r + {{(AW-2){1'b0}}, 2'd2}) : {AW{1'b0}};
            first_done_r <= (state_r == ST_RUN) && (state_next_s == ST_DONE);
        end
    end

    // Config latched in ARM; pulse levels are pre-saturated here.
    always_ff @(posedge rxclk or posedge rst) begin
        if (rst) begin
            t_a_r     <= {AW{1'b0}};
            t_b_r     <= {AW{1'b0}};
            t_c_r     <= {AW{1'b0}};
            t_e_r     <= {AW{1'b0}};
            tof_r     <= {AW{1'b0}};
            width_r   <= {DW{1'b0}};
            base_r    <= {DW{1'b0}};
            lev_a_r   <= {DW{1'b0}};
            lev_b_r   <= {DW{1'b0}};
            lev_c_r   <= {DW{1'b0}};
            cfg_err_r <= 1'b0;
        end else if (state_r == ST_ARM) begin
            t_a_r   <= t_a_s[AW-1:0];
            t_b_r   <= t_b_s[AW-1:0];
            t_c_r   <= t_c_s[AW-1:0];
            t_e_r   <= t_e_s[AW-1:0];
            tof_r   <= delay_ab >> 1;
            width_r <= pulse_width;
            base_r  <= baseline;
            lev_a_r <= sat_add(baseline, amp_a);
            lev_b_r <= sat_add(baseline, amp_b);
            lev_c_r <= sat_add(baseline, amp_c);
            if (gen_enable) begin
                cfg_err_r <= sched_ovf_s;
            end
        end
    end

    // Output registers.
    always_ff @(posedge rxclk or posedge rst) begin
        if (rst) begin
            data_a_r <= {TW{1'b0}};
            data_b_r <= {TW{1'b0}};
            data_c_r <= {TW{1'b0}};
            data_d_r <= {TW{1'b0}};
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            data_a_r <= data_a_s;
            data_b_r <= data_b_s;
            data_c_r <= data_c_s;
            data_d_r <= data_d_s;
            valid_r  <= valid_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign adc_data_a    = data_a_r;
    assign adc_data_b    = data_b_r;
    assign adc_data_c    = data_c_r;
    assign adc_data_d    = data_d_r;
    assign adc_valid     = valid_r;
    assign gen_busy      = busy_r;
    assign gen_done      = done_r;
    assign cfg_err       = cfg_err_r;
    assign tof_ab_cycles = tof_r;
endmodule

// File: tb/tb_adc_pulse_emulator.sv
// Scoreboard bench for adc_pulse_emulator: a sample-level reference model queues the
// expected word stream per run; a monitor pops and compares whenever adc_valid is high.
module tb_adc_pulse_emulator;
    logic        rxclk = 1'b0;
    logic        rst, gen_enable, gen_start;
    logic [15:0] baseline, amp_a, amp_b, amp_c, pulse_width;
    logic [31:0] init_delay, delay_ab, delay_bc;
    logic [31:0] adc_data_a, adc_data_b, adc_data_c, adc_data_d, tof_ab_cycles;
    logic        adc_valid, gen_busy, gen_done, cfg_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] a, b, c, d;
        logic        done;
    } item_t;

    typedef struct {
        logic [15:0] base, amp_a, amp_b, amp_c, width;
        logic [31:0] init, ab, bc;
    } cfg_t;

    item_t       exp_q[$];
    item_t       mon_e;
    logic [15:0] exp_base = 16'h0000;

    always #4 rxclk = ~rxclk;

    adc_pulse_emulator dut (
        .rxclk(rxclk), .rst(rst), .gen_enable(gen_enable), .gen_start(gen_start),
        .baseline(baseline), .amp_a(amp_a), .amp_b(amp_b), .amp_c(amp_c),
        .init_delay(init_delay), .delay_ab(delay_ab), .delay_bc(delay_bc),
        .pulse_width(pulse_width),
        .adc_data_a(adc_data_a), .adc_data_b(adc_data_b), .adc_data_c(adc_data_c),
        .adc_data_d(adc_data_d), .adc_valid(adc_valid), .gen_busy(gen_busy),
        .gen_done(gen_done), .cfg_err(cfg_err), .tof_ab_cycles(tof_ab_cycles)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Value of one sample on one channel: signed sum clamped to 16 bits inside the pulse window.
    function automatic logic [15:0] model_sample(longint s, longint t, longint w,
                                                 logic [15:0] base, logic [15:0] amp);
        int v;
        if (s >= t && s < t + w) begin
            v = int'($signed(base)) + int'($signed(amp));
            if (v > 32767)  v = 32767;
            if (v < -32768) v = -32768;
            return 16'(v);
        end
        return base;
    endfunction

    // Queue the words of one run; limit >= 0 truncates the stream (aborted run).
    task automatic model_push(input cfg_t c, input int limit, output bit ovf);
        longint ta, tb, tc, te, w, n;
        int     cnt;
        bit     ended;
        item_t  it;
        ta  = longint'(c.init);
        tb  = ta + longint'(c.ab);
        tc  = tb + longint'(c.bc);
        w   = longint'(c.width);
        te  = tc + w;
        ovf = (te > 64'h0000_0000_FFFF_FFFF);
        if (!ovf) begin
            cnt = 0; n = 0; ended = 1'b0;
            while (!ended && cnt != limit) begin
                it.a = {model_sample(n + 1, ta, w, c.base, c.amp_a), model_sample(n, ta, w, c.base, c.amp_a)};
                it.b = {model_sample(n + 1, tb, w, c.base, c.amp_b), model_sample(n, tb, w, c.base, c.amp_b)};
                it.c = {model_sample(n + 1, tc, w, c.base, c.amp_c), model_sample(n, tc, w, c.base, c.amp_c)};
                it.d = {c.base, c.base};
                it.done = 1'b0;
                exp_q.push_back(it);
                cnt++;
                if (n + 2 >= te) ended = 1'b1;
                n += 2;
            end
            if (ended) begin
                it.a = {c.base, c.base}; it.b = it.a; it.c = it.a; it.d = it.a;
                it.done = 1'b1;
                exp_q.push_back(it);
            end
        end
    endtask

    // Monitor: consume expected words while valid; afterwards DONE must hold baseline.
    always @(negedge rxclk) begin
        if (!rst) begin
            if (adc_valid) begin
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("word_a", adc_data_a, mon_e.a);
                    check("word_b", adc_data_b, mon_e.b);
                    check("word_c", adc_data_c, mon_e.c);
                    check("word_d", adc_data_d, mon_e.d);
                    check("gen_done", gen_done, mon_e.done);
                end else begin
                    check("hold_a", adc_data_a, {exp_base, exp_base});
                    check("hold_d", adc_data_d, {exp_base, exp_base});
                    check("hold_done", gen_done, 1'b0);
                end
            end else begin
                check("invalid_done", gen_done, 1'b0);
            end
        end
    end

    task automatic run(input cfg_t c, input int abort_m, input bit scramble, input bit start_mid);
        bit ovf;
        int guard;
        @(negedge rxclk);
        baseline = c.base; amp_a = c.amp_a; amp_b = c.amp_b; amp_c = c.amp_c;
        init_delay = c.init; delay_ab = c.ab; delay_bc = c.bc; pulse_width = c.width;
        gen_enable = 1'b1; gen_start = 1'b1;
        exp_base = c.base;
        model_push(c, abort_m, ovf);
        @(negedge rxclk);
        gen_start = 1'b0;
        check("busy_arm", gen_busy, 1'b1);
        @(negedge rxclk);
        check("tof", tof_ab_cycles, c.ab >> 1);
        if (ovf) begin
            check("cfg_err_set", cfg_err, 1'b1);
            check("ovf_valid", adc_valid, 1'b0);
            check("ovf_busy", gen_busy, 1'b0);
            return;
        end
        if (scramble) begin
            baseline = 16'($urandom); amp_a = 16'($urandom); amp_b = 16'($urandom);
            amp_c = 16'($urandom); init_delay = $urandom; delay_ab = $urandom;
            delay_bc = $urandom; pulse_width = 16'($urandom);
        end
        if (abort_m >= 0) begin
            repeat (abort_m) @(negedge rxclk);
            gen_enable = 1'b0;
            @(negedge rxclk);
            check("abort_valid", adc_valid, 1'b0);
            check("abort_busy", gen_busy, 1'b0);
            check("abort_a", adc_data_a, {c.base, c.base});
            check("abort_b", adc_data_b, {c.base, c.base});
            repeat (4) begin
                @(negedge rxclk);
                check("abort_no_done", gen_done, 1'b0);
            end
            check("abort_drain", exp_q.size(), 0);
            exp_q.delete();
            gen_enable = 1'b1;
            return;
        end
        if (start_mid) begin
            gen_start = 1'b1;
            @(negedge rxclk);
            gen_start = 1'b0;
        end
        guard = 0;
        while (exp_q.size() != 0 && guard < 400) begin
            @(negedge rxclk);
            guard++;
        end
        check("run_drain", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge rxclk);
        check("done_busy", gen_busy, 1'b0);
        check("cfg_err_clr", cfg_err, 1'b0);
        gen_enable = 1'b0;
        @(negedge rxclk);
        gen_enable = 1'b1;
    endtask

    function automatic cfg_t mk(logic [15:0] base, logic [15:0] aa, logic [15:0] ab_amp, logic [15:0] ac,
                                logic [31:0] init, logic [31:0] ab, logic [31:0] bc, logic [15:0] w);
        cfg_t c;
        c.base = base; c.amp_a = aa; c.amp_b = ab_amp; c.amp_c = ac;
        c.init = init; c.ab = ab; c.bc = bc; c.width = w;
        return c;
    endfunction

    initial begin
        cfg_t c;
        rst = 1'b1; gen_enable = 1'b0; gen_start = 1'b0;
        baseline = 16'h1234; amp_a = 16'h0000; amp_b = 16'h0000; amp_c = 16'h0000;
        init_delay = 32'd0; delay_ab = 32'd0; delay_bc = 32'd0; pulse_width = 16'd0;
        repeat (3) @(negedge rxclk);
        check("rst_a", adc_data_a, 32'h0);
        check("rst_d", adc_data_d, 32'h0);
        check("rst_valid", adc_valid, 1'b0);
        check("rst_busy", gen_busy, 1'b0);
        check("rst_done", gen_done, 1'b0);
        check("rst_cfg_err", cfg_err, 1'b0);
        check("rst_tof", tof_ab_cycles, 32'h0);
        rst = 1'b0;
        @(negedge rxclk);
        gen_enable = 1'b1;
        @(negedge rxclk);
        check("idle_a", adc_data_a, 32'h1234_1234);
        check("idle_valid", adc_valid, 1'b0);

        run(mk(16'h0000, 16'd1000, 16'h0000, 16'h0000, 32'd4, 32'd2, 32'd2, 16'd2), -1, 1'b0, 1'b0);
        run(mk(16'h0000, 16'h0100, 16'h0040, 16'h0020, 32'd5, 32'd7, 32'd3, 16'd1), -1, 1'b0, 1'b0);
        run(mk(16'h7F00, 16'h0050, 16'h0200, 16'h0000, 32'd1, 32'd3, 32'd2, 16'd3), -1, 1'b0, 1'b0);
        run(mk(16'h8100, 16'h7FFF, 16'h0000, 16'h8000, 32'd0, 32'd2, 32'd3, 16'd4), -1, 1'b0, 1'b0);
        run(mk(16'h0000, 16'h0001, 16'h0001, 16'h0001, 32'hFFFF_FFF0, 32'h20, 32'd0, 16'd4), -1, 1'b0, 1'b0);
        run(mk(16'h0000, 16'h0011, 16'h0022, 16'h0033, 32'd1, 32'd1, 32'd1, 16'd1), -1, 1'b0, 1'b0);
        run(mk(16'h0010, 16'h0000, 16'd500, 16'h0000, 32'd2, 32'd10, 32'd10, 16'd6), 7, 1'b0, 1'b0);
        run(mk(16'hFFF0, 16'h0100, 16'h0200, 16'h0300, 32'd0, 32'd10, 32'd10, 16'd4), -1, 1'b1, 1'b1);
        run(mk(16'h0005, 16'h1000, 16'h2000, 16'h3000, 32'd3, 32'd2, 32'd1, 16'd0), -1, 1'b0, 1'b0);
        run(mk(16'h0007, 16'h1000, 16'h2000, 16'h3000, 32'd0, 32'd0, 32'd0, 16'd0), -1, 1'b0, 1'b0);
        run(mk(16'h0000, 16'h0100, 16'h0200, 16'h0300, 32'd3, 32'd1, 32'd0, 16'd5), -1, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            c = mk(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                   32'($urandom_range(0, 40)), 32'($urandom_range(0, 30)),
                   32'($urandom_range(0, 30)), 16'($urandom_range(0, 12)));
            run(c, -1, 1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (4) @(negedge rxclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule
